// File: rtl/psum_readout_streamer.sv
// psum_readout_streamer: walks a psum bank window, requantizes each read to OUT_W bits and streams it out via a credit-limited FIFO
module psum_readout_streamer #(
  parameter int DATA_W     = 21,
  parameter int ADDR_W     = 10,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        depth,
  input  logic [4:0]        shift,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              bank_read_out_en,
  output logic              bank_data_out_ready,
  output logic [ADDR_W-1:0] bank_read_addr,
  input  logic              bank_write_en,
  input  logic              bank_data_out_valid,
  input  logic [DATA_W-1:0] bank_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [DATA_W:0] MAX_V = (DATA_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [DATA_W:0] MIN_V = -MAX_V - 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [4:0] depth_q, depth_d, shift_q, shift_d, issue_cnt_q, issue_cnt_d, cap_cnt_q, cap_cnt_d;
  logic relu_q, relu_d;
  logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OUT_W:0] mem_q [FIFO_DEPTH];
  logic [OUT_W:0] mem_d [FIFO_DEPTH];
  logic issue, capture, pop;
  logic signed [DATA_W:0] rnd, sum, r, rq;
  logic [OUT_W-1:0] q;
  always_comb begin
    // credits count both FIFO entries and reads still in flight, so a push always has room
    issue = state_q == ISSUE && ({1'b0, count_q} + {1'b0, inflight_q} < (CW+1)'(FIFO_DEPTH)) && !bank_write_en;
    capture = bank_data_out_valid && inflight_q != '0;
    pop = out_valid && out_ready;
    rnd = shift_q == 5'd0 ? '0 : (DATA_W+1)'(1) << (shift_q - 5'd1);
    sum = $signed({bank_data_out[DATA_W-1], bank_data_out}) + rnd;
    r = sum >>> shift_q;
    rq = (relu_q && r < 0) ? '0 : r;
    q = rq > MAX_V ? MAX_V[OUT_W-1:0] : rq < MIN_V ? MIN_V[OUT_W-1:0] : rq[OUT_W-1:0];
    inflight_d = inflight_q + CW'(issue) - CW'(capture);
    count_d = count_q + CW'(capture) - CW'(pop);
    wr_d = capture ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    mem_d = mem_q;
    if (capture) mem_d[wr_q] = {cap_cnt_q == depth_q, q};
    addr_d = issue ? base_q + ADDR_W'(issue_cnt_q) : addr_q;
    cap_cnt_d = capture ? cap_cnt_q + 5'd1 : cap_cnt_q;
    issue_cnt_d = issue ? issue_cnt_q + 5'd1 : issue_cnt_q;
    state_d = state_q;
    base_d = base_q;
    depth_d = depth_q;
    shift_d = shift_q;
    relu_d = relu_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        base_d = base_addr;
        depth_d = depth;
        shift_d = shift;
        relu_d = relu_en;
        issue_cnt_d = '0;
        cap_cnt_d = '0;
      end
      ISSUE: state_d = (issue && issue_cnt_q == depth_q) ? DRAIN : ISSUE;
      DRAIN: state_d = (inflight_d == '0 && count_d == '0) ? DONE : DRAIN;
      DONE: state_d = IDLE;
    endcase
    busy = state_q != IDLE;
    done = state_q == DONE;
    bank_read_out_en = issue;
    bank_data_out_ready = issue;
    bank_read_addr = addr_d;
    out_valid = count_q != '0;
    {out_last, out_data} = out_valid ? mem_q[rd_q] : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      addr_q <= '0;
      depth_q <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q <= '0;
      inflight_q <= '0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_q <= addr_d;
      depth_q <= depth_d;
      shift_q <= shift_d;
      relu_q <= relu_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_psum_readout_streamer.sv
// tb_psum_readout_streamer: directed passes against a behavioural bank, with address and output scoreboards
module tb_psum_readout_streamer;
  logic clock = 1'b0;
  logic reset, start, relu_en, busy, done, bank_read_out_en, bank_data_out_ready;
  logic bank_write_en, bank_data_out_valid, out_valid, out_ready, out_last;
  logic [9:0] base_addr, bank_read_addr;
  logic [4:0] depth, shift;
  logic [20:0] bank_data_out;
  logic [7:0] out_data;
  logic [20:0] bank_mem [1024];
  int tests = 0, fails = 0, done_cnt = 0, req_cnt = 0;
  logic [9:0] exp_addr_q [$];
  logic [8:0] exp_q [$];
  logic [9:0] last_addr = '0;
  logic stall_p = 1'b0;
  logic [8:0] stall_v = '0;

  always #5 clock = ~clock;

  psum_readout_streamer dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .depth(depth),
    .shift(shift), .relu_en(relu_en), .busy(busy), .done(done),
    .bank_read_out_en(bank_read_out_en), .bank_data_out_ready(bank_data_out_ready),
    .bank_read_addr(bank_read_addr), .bank_write_en(bank_write_en),
    .bank_data_out_valid(bank_data_out_valid), .bank_data_out(bank_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always @(posedge clock) begin
    bank_data_out_valid <= bank_read_out_en;
    bank_data_out <= bank_read_out_en ? bank_mem[bank_read_addr] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input int x, input int sh, input bit relu, input bit last);
    int r;
    r = (sh == 0) ? x : ((x + (1 << (sh - 1))) >>> sh);
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return {last, 8'(r)};
  endfunction

  task automatic cyc();
    logic [9:0] ea;
    logic [8:0] ed;
    @(negedge clock);
    if (!reset) begin
      if (bank_read_out_en) begin
        req_cnt++;
        chk("strobe_pair", 32'(bank_data_out_ready), 1);
        chk("no_issue_on_write", 32'(bank_write_en), 0);
        chk("req_expected", 32'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          chk("addr", 32'(bank_read_addr), 32'(ea));
          last_addr = ea;
        end
      end else begin
        chk("ready_low", 32'(bank_data_out_ready), 0);
        chk("addr_hold", 32'(bank_read_addr), 32'(last_addr));
      end
      if (stall_p) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_hold", 32'({out_last, out_data}), 32'(stall_v));
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          ed = exp_q.pop_front();
          chk("out_data", 32'({out_last, out_data}), 32'(ed));
        end
      end
      stall_p = out_valid && !out_ready;
      stall_v = {out_last, out_data};
      if (done) done_cnt++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_mem(input int a, input int v);
    bank_mem[a] = 21'(v);
  endtask

  task automatic begin_pass(input int b, input int d, input int s, input bit rl);
    int a;
    for (int i = 0; i <= d; i++) begin
      a = (b + i) % 1024;
      exp_addr_q.push_back(10'(a));
      exp_q.push_back(model($signed(bank_mem[a]), s, rl, i == d));
    end
    done_cnt = 0;
    base_addr = 10'(b);
    depth = 5'(d);
    shift = 5'(s);
    relu_en = rl;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_high", 32'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("done_seen", 32'(done_cnt), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("addr_sb_empty", 32'(exp_addr_q.size()), 0);
    chk("busy_after", 32'(busy), 0);
    repeat (3) cyc();
    chk("single_done", 32'(done_cnt), 1);
  endtask

  task automatic check_idle();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_en", 32'(bank_read_out_en), 0);
    chk("idle_ready", 32'(bank_data_out_ready), 0);
    chk("idle_addr", 32'(bank_read_addr), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_data", 32'(out_data), 0);
    chk("idle_last", 32'(out_last), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; bank_write_en = 1'b0; out_ready = 1'b1;
    base_addr = '0; depth = '0; shift = '0;
    repeat (3) cyc();
    reset = 1'b0;
    check_idle();
    set_mem(0, 5); set_mem(1, -7); set_mem(2, 100); set_mem(3, -200);
    begin_pass(0, 3, 0, 0);
    wait_done(50);
    set_mem(10, 24); set_mem(11, -24); set_mem(12, 2047);
    begin_pass(10, 2, 4, 0);
    wait_done(50);
    begin_pass(10, 2, 4, 1);
    wait_done(50);
    set_mem(20, -1048576); set_mem(21, 1048575);
    begin_pass(20, 1, 20, 0);
    wait_done(50);
    for (int i = 100; i < 116; i++) set_mem(i, int'($urandom_range(0, 4000)) - 2000);
    out_ready = 1'b0;
    req_cnt = 0;
    begin_pass(100, 15, 2, 0);
    repeat (12) cyc();
    chk("credit_reqs", 32'(req_cnt), 4);
    chk("credit_strobe_low", 32'(bank_read_out_en), 0);
    chk("credit_fifo_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    wait_done(100);
    for (int i = 200; i < 208; i++) set_mem(i, int'($urandom_range(0, 600)) - 300);
    begin_pass(200, 7, 1, 1);
    cyc(); cyc();
    bank_write_en = 1'b1;
    repeat (3) cyc();
    bank_write_en = 1'b0;
    wait_done(100);
    set_mem(1022, 11); set_mem(1023, -12); set_mem(0, 13); set_mem(1, -14);
    begin_pass(1022, 3, 0, 0);
    cyc();
    base_addr = 10'd500; depth = 5'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(50);
    for (int i = 300; i < 316; i++) set_mem(i, i);
    out_ready = 1'b0;
    begin_pass(300, 15, 0, 0);
    repeat (3) cyc();
    chk("pre_reset_valid", 32'(out_valid), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle();
    exp_q.delete(); exp_addr_q.delete();
    last_addr = '0; stall_p = 1'b0; done_cnt = 0; out_ready = 1'b1;
    repeat (5) cyc();
    chk("no_done_after_reset", 32'(done_cnt), 0);
    chk("fifo_cleared", 32'(out_valid), 0);
    set_mem(0, 5); set_mem(1, -7); set_mem(2, 100); set_mem(3, -200);
    begin_pass(0, 3, 0, 0);
    wait_done(50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
